// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the program loader controller
//
// Purpose: FSM state encoding, byte-lane index type and default exit code
// used by program_loader_ctrl and its word_serializer.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        EMIT    = 3'd2,
        RELEASE = 3'd3,
        RUN     = 3'd4,
        DONE    = 3'd5
    } state_t;

    // riscv-tests exit syscall number placed in a7
    localparam int unsigned EXIT_CODE_DEFAULT = 93;

    // Selects one of the four bytes of a 32-bit program word
    typedef logic [1:0] lane_t;

endpackage

// File: rtl/program_loader_ctrl_word_serializer.sv
// rtl/program_loader_ctrl_word_serializer.sv - splits a program word into four little-endian byte beats
//
// Purpose: holds one program word and, one beat per step_i, presents its
// bytes lowest lane first together with a byte address that wraps modulo
// MEM_DEPTH. A wrap sets a sticky overflow flag.
// Ports:
//   clock, reset     system clock, synchronous active-high reset
//   clear_i          new session: address and overflow back to zero
//   load_i, data_i   capture a word, restart at lane 0
//   step_i           advance one byte beat (lane and address)
//   byte_o           byte of the current lane
//   addr_o           byte address of the current beat
//   lane_last_o      current lane is the final byte of the word
//   overflow_o       sticky: address wrapped past MEM_DEPTH-1
module word_serializer
    import program_loader_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MEM_DEPTH = 16384
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             step_i,
    output logic [7:0]       byte_o,
    output logic [WIDTH-1:0] addr_o,
    output logic             lane_last_o,
    output logic             overflow_o
);

    localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(MEM_DEPTH - 1);

    logic [WIDTH-1:0] word_q;
    lane_t            lane_q;
    logic [WIDTH-1:0] addr_q;
    logic             overflow_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            word_q     <= '0;
            lane_q     <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (clear_i) begin
                addr_q     <= '0;
                overflow_q <= 1'b0;
                lane_q     <= '0;
            end
            if (load_i) begin
                word_q <= data_i;
                lane_q <= '0;
            end
            if (step_i) begin
                lane_q <= lane_t'(lane_q + 2'd1);
                if (addr_q == LAST_ADDR) begin
                    addr_q     <= '0;
                    overflow_q <= 1'b1;
                end else begin
                    addr_q <= addr_q + WIDTH'(1);
                end
            end
        end
    end

    assign byte_o      = word_q[{lane_q, 3'b000} +: 8];
    assign addr_o      = addr_q;
    assign lane_last_o = (lane_q == 2'd3);
    assign overflow_o  = overflow_q;

endmodule

// File: rtl/program_loader_ctrl.sv
// rtl/program_loader_ctrl.sv - load, release and monitor sequencer for the RV32 core
//
// Purpose: streams a program image into the core through its byte load port
// while holding the core in reset, then runs it and watches gp/a7/a0 for the
// riscv-tests exit convention, reporting pass, fail or timeout.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   start                        begin a session (honoured in IDLE/DONE only)
//   in_valid/in_ready/in_data/in_last  program word stream
//   proc_reset                   core reset, low only while running
//   memEn/memData/memAddr        core byte load port
//   gp, a7, a0                   core registers watched during RUN
//   busy, done, pass, timeout    session status
//   overflow                     sticky load-address wrap
//   fail_test                    gp>>1 on a failing exit
//   run_cycles                   cycles counted in RUN
module program_loader_ctrl
    import program_loader_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned MEM_DEPTH    = 16384,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 100000,
    parameter int unsigned EXIT_CODE    = EXIT_CODE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             proc_reset,
    output logic             memEn,
    output logic [WIDTH-1:0] memData,
    output logic [WIDTH-1:0] memAddr,
    input  logic [WIDTH-1:0] gp,
    input  logic [WIDTH-1:0] a7,
    input  logic [WIDTH-1:0] a0,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             overflow,
    output logic [WIDTH-1:0] fail_test,
    output logic [WIDTH-1:0] run_cycles
);

    localparam logic [WIDTH-1:0] EXIT_W   = WIDTH'(EXIT_CODE);
    localparam logic [WIDTH-1:0] MAX_LAST = WIDTH'(MAX_CYCLES - 1);
    localparam logic [15:0]      RST_LAST = 16'(RESET_CYCLES - 1);

    state_t           state_q, state_d;
    logic             last_q;
    logic [15:0]      rst_cnt_q;
    logic [WIDTH-1:0] run_cycles_q;
    logic             pass_q;
    logic             timeout_q;
    logic [WIDTH-1:0] fail_test_q;

    logic             start_sess;
    logic             accept;
    logic             exit_hit;
    logic             limit_hit;
    logic [7:0]       ser_byte;
    logic [WIDTH-1:0] ser_addr;
    logic             ser_lane_last;
    logic             ser_overflow;

    assign start_sess = start && ((state_q == IDLE) || (state_q == DONE));
    assign accept     = in_valid && (state_q == LOAD);
    assign exit_hit   = (a7 == EXIT_W);
    assign limit_hit  = (run_cycles_q == MAX_LAST);

    word_serializer #(
        .WIDTH     (WIDTH),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_serializer (
        .clock       (clock),
        .reset       (reset),
        .clear_i     (start_sess),
        .load_i      (accept),
        .data_i      (in_data),
        .step_i      (state_q == EMIT),
        .byte_o      (ser_byte),
        .addr_o      (ser_addr),
        .lane_last_o (ser_lane_last),
        .overflow_o  (ser_overflow)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_sess) state_d = LOAD;
            LOAD:    if (accept) state_d = EMIT;
            EMIT:    if (ser_lane_last) state_d = last_q ? RELEASE : LOAD;
            RELEASE: if (rst_cnt_q == RST_LAST) state_d = RUN;
            RUN:     if (exit_hit || limit_hit) state_d = DONE;
            DONE:    if (start_sess) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b0;
            rst_cnt_q    <= '0;
            run_cycles_q <= '0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_test_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= in_last;
            end
            rst_cnt_q <= (state_q == RELEASE) ? rst_cnt_q + 16'd1 : 16'd0;
            if (start_sess) begin
                run_cycles_q <= '0;
                pass_q       <= 1'b0;
                timeout_q    <= 1'b0;
                fail_test_q  <= '0;
            end else if (state_q == RUN) begin
                // Exit is checked first so it wins over a coincident timeout;
                // the counter stops on the cycle that leaves RUN.
                if (exit_hit) begin
                    pass_q      <= (a0 == '0);
                    fail_test_q <= (a0 == '0) ? '0 : (gp >> 1);
                end else if (limit_hit) begin
                    timeout_q <= 1'b1;
                end else begin
                    run_cycles_q <= run_cycles_q + WIDTH'(1);
                end
            end
        end
    end

    assign in_ready   = (state_q == LOAD);
    assign memEn      = (state_q == EMIT);
    assign memData    = memEn ? {{(WIDTH-8){1'b0}}, ser_byte} : '0;
    assign memAddr    = ser_addr;
    assign proc_reset = (state_q != RUN);
    assign busy       = (state_q == LOAD) || (state_q == EMIT) ||
                        (state_q == RELEASE) || (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign timeout    = timeout_q;
    assign overflow   = ser_overflow;
    assign fail_test  = fail_test_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_program_loader_ctrl.sv
// tb/tb_program_loader_ctrl.sv - directed self-checking bench for program_loader_ctrl
module tb_program_loader_ctrl;

    localparam int RC = 2;
    localparam int MC = 50;

    logic        clock = 1'b0;
    logic        reset, start, in_valid, in_last;
    logic [31:0] in_data, gp, a7, a0;

    logic        a_in_ready, a_proc_reset, a_memEn, a_busy, a_done, a_pass, a_timeout, a_overflow;
    logic [31:0] a_memData, a_memAddr, a_fail_test, a_run_cycles;
    logic        b_in_ready, b_proc_reset, b_memEn, b_busy, b_done, b_pass, b_timeout, b_overflow;
    logic [31:0] b_memData, b_memAddr, b_fail_test, b_run_cycles;

    int checks = 0;
    int errors = 0;

    logic [31:0] prog [3] = '{32'h0000_0013, 32'h05D0_0893, 32'h0000_0073};
    logic [7:0]  exp_bytes [12] = '{8'h13, 8'h00, 8'h00, 8'h00,
                                    8'h93, 8'h08, 8'hD0, 8'h05,
                                    8'h73, 8'h00, 8'h00, 8'h00};
    // Expected addresses on the MEM_DEPTH=8 instance
    logic [31:0] exp_addr_b [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};

    always #5 clock = ~clock;

    program_loader_ctrl #(.WIDTH(32), .MEM_DEPTH(16384), .RESET_CYCLES(RC), .MAX_CYCLES(MC)) dut_a (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .proc_reset(a_proc_reset), .memEn(a_memEn),
        .memData(a_memData), .memAddr(a_memAddr), .gp(gp), .a7(a7), .a0(a0), .busy(a_busy),
        .done(a_done), .pass(a_pass), .timeout(a_timeout), .overflow(a_overflow),
        .fail_test(a_fail_test), .run_cycles(a_run_cycles));

    program_loader_ctrl #(.WIDTH(32), .MEM_DEPTH(8), .RESET_CYCLES(RC), .MAX_CYCLES(MC)) dut_b (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .proc_reset(b_proc_reset), .memEn(b_memEn),
        .memData(b_memData), .memAddr(b_memAddr), .gp(gp), .a7(a7), .a0(a0), .busy(b_busy),
        .done(b_done), .pass(b_pass), .timeout(b_timeout), .overflow(b_overflow),
        .fail_test(b_fail_test), .run_cycles(b_run_cycles));

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        gp = '0; a7 = '0; a0 = '0;
        step; step;
        reset = 1'b0;
        checks++;
        if ({a_proc_reset, a_memEn, a_in_ready, a_busy, a_done, a_pass, a_timeout, a_overflow} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 10000000",
                     {a_proc_reset, a_memEn, a_in_ready, a_busy, a_done, a_pass, a_timeout, a_overflow});
        end
        checks++;
        if ({a_memData, a_memAddr, a_fail_test, a_run_cycles} !== 128'h0) begin
            errors++;
            $display("FAIL reset_words: got %h want 0", {a_memData, a_memAddr, a_fail_test, a_run_cycles});
        end
    endtask

    task automatic test_ignored_inputs;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        checks++;
        if (a_in_ready !== 1'b0) begin
            errors++; $display("FAIL idle_ready: got %b want 0", a_in_ready);
        end
        step;
        in_valid = 1'b0;
        checks++;
        if ({a_busy, a_memEn, a_proc_reset} !== 3'b001) begin
            errors++; $display("FAIL idle_ignore_valid: got %b want 001", {a_busy, a_memEn, a_proc_reset});
        end
    endtask

    task automatic begin_session;
        start = 1'b1;
        step;
        start = 1'b0;
        checks++;
        if ({a_busy, a_in_ready, a_done, a_pass, a_timeout, a_overflow, b_overflow} !== 7'b1100000) begin
            errors++;
            $display("FAIL session_clear: got %b want 1100000",
                     {a_busy, a_in_ready, a_done, a_pass, a_timeout, a_overflow, b_overflow});
        end
        checks++;
        if ({a_run_cycles, a_fail_test} !== 64'h0) begin
            errors++; $display("FAIL session_counters: got %h want 0", {a_run_cycles, a_fail_test});
        end
    endtask

    // Entered in LOAD; leaves the DUTs in their first RUN cycle.
    task automatic load_program;
        int k;
        k = 0;
        for (int w = 0; w < 3; w++) begin
            if (w == 1) begin
                step;
                checks++;
                if ({a_in_ready, a_memEn} !== 2'b10) begin
                    errors++; $display("FAIL load_gap: got %b want 10", {a_in_ready, a_memEn});
                end
            end
            in_valid = 1'b1; in_data = prog[w]; in_last = (w == 2);
            checks++;
            if (a_in_ready !== 1'b1) begin
                errors++; $display("FAIL load_ready w%0d: got %b want 1", w, a_in_ready);
            end
            step;
            in_valid = 1'b0; in_last = 1'b0; in_data = '0;
            for (int b = 0; b < 4; b++) begin
                checks++;
                if ({a_memEn, a_in_ready, a_proc_reset} !== 3'b101) begin
                    errors++;
                    $display("FAIL emit_ctl beat%0d: got %b want 101", k, {a_memEn, a_in_ready, a_proc_reset});
                end
                checks++;
                if (a_memAddr !== 32'(k) || a_memData !== {24'h0, exp_bytes[k]}) begin
                    errors++;
                    $display("FAIL emit_a beat%0d: got addr %0d data %h want addr %0d data %h",
                             k, a_memAddr, a_memData, k, exp_bytes[k]);
                end
                checks++;
                if (b_memAddr !== exp_addr_b[k] || b_memData !== {24'h0, exp_bytes[k]}) begin
                    errors++;
                    $display("FAIL emit_b beat%0d: got addr %0d data %h want addr %0d data %h",
                             k, b_memAddr, b_memData, exp_addr_b[k], exp_bytes[k]);
                end
                k++;
                step;
            end
        end
        for (int r = 0; r < RC; r++) begin
            checks++;
            if ({a_memEn, a_proc_reset, a_busy, a_in_ready} !== 4'b0110) begin
                errors++;
                $display("FAIL release%0d: got %b want 0110", r, {a_memEn, a_proc_reset, a_busy, a_in_ready});
            end
            step;
        end
        checks++;
        if ({a_proc_reset, b_proc_reset, a_busy} !== 3'b001) begin
            errors++; $display("FAIL run_entry: got %b want 001", {a_proc_reset, b_proc_reset, a_busy});
        end
        checks++;
        if ({a_overflow, b_overflow} !== 2'b01) begin
            errors++; $display("FAIL overflow: got %b want 01", {a_overflow, b_overflow});
        end
    endtask

    task automatic test_load_and_pass;
        begin_session;
        load_program;
        gp = 32'd1; a0 = 32'd0; a7 = 32'd0;
        for (int i = 0; i < 5; i++) step;
        start = 1'b1;
        step;
        start = 1'b0;
        checks++;
        if ({a_proc_reset, a_busy, a_in_ready, a_done} !== 4'b0100 || a_run_cycles !== 32'd6) begin
            errors++;
            $display("FAIL run_start_ignored: got %b rc %0d want 0100 rc 6",
                     {a_proc_reset, a_busy, a_in_ready, a_done}, a_run_cycles);
        end
        a7 = 32'd93;
        step;
        checks++;
        if ({a_done, a_pass, a_timeout, a_busy, a_proc_reset} !== 5'b11001) begin
            errors++;
            $display("FAIL pass_flags: got %b want 11001", {a_done, a_pass, a_timeout, a_busy, a_proc_reset});
        end
        checks++;
        if (a_fail_test !== 32'd0 || a_run_cycles !== 32'd6) begin
            errors++; $display("FAIL pass_words: got ft %0d rc %0d want 0 6", a_fail_test, a_run_cycles);
        end
        a7 = 32'd0; gp = 32'd9; a0 = 32'd5;
        step; step;
        checks++;
        if ({a_done, a_pass, a_proc_reset} !== 3'b111 || a_run_cycles !== 32'd6) begin
            errors++;
            $display("FAIL done_hold: got %b rc %0d want 111 rc 6", {a_done, a_pass, a_proc_reset}, a_run_cycles);
        end
    endtask

    task automatic test_fail_exit;
        begin_session;
        a7 = 32'd0; gp = 32'd0; a0 = 32'd0;
        load_program;
        gp = 32'd7; a0 = 32'd7; a7 = 32'd93;
        step;
        a7 = 32'd0;
        checks++;
        if ({a_done, a_pass, a_timeout} !== 3'b100) begin
            errors++; $display("FAIL fail_flags: got %b want 100", {a_done, a_pass, a_timeout});
        end
        checks++;
        if (a_fail_test !== 32'd3 || a_run_cycles !== 32'd0) begin
            errors++; $display("FAIL fail_words: got ft %0d rc %0d want 3 0", a_fail_test, a_run_cycles);
        end
    endtask

    task automatic test_timeout;
        begin_session;
        gp = 32'd0; a0 = 32'd0; a7 = 32'd0;
        load_program;
        for (int i = 0; i < MC - 1; i++) step;
        checks++;
        if ({a_busy, a_proc_reset, a_done} !== 3'b100 || a_run_cycles !== 32'd49) begin
            errors++;
            $display("FAIL pre_timeout: got %b rc %0d want 100 rc 49", {a_busy, a_proc_reset, a_done}, a_run_cycles);
        end
        step;
        checks++;
        if ({a_done, a_timeout, a_pass, a_proc_reset} !== 4'b1101 || a_run_cycles !== 32'd49 || a_fail_test !== 32'd0) begin
            errors++;
            $display("FAIL timeout: got %b rc %0d ft %0d want 1101 rc 49 ft 0",
                     {a_done, a_timeout, a_pass, a_proc_reset}, a_run_cycles, a_fail_test);
        end
    endtask

    task automatic test_exit_beats_timeout;
        begin_session;
        load_program;
        for (int i = 0; i < MC - 1; i++) step;
        a7 = 32'd93; a0 = 32'd0;
        step;
        a7 = 32'd0;
        checks++;
        if ({a_done, a_pass, a_timeout} !== 3'b110 || a_run_cycles !== 32'd49) begin
            errors++;
            $display("FAIL exit_vs_timeout: got %b rc %0d want 110 rc 49", {a_done, a_pass, a_timeout}, a_run_cycles);
        end
    endtask

    task automatic test_reset_mid_emit;
        begin_session;
        in_valid = 1'b1; in_data = prog[1]; in_last = 1'b0;
        step;
        in_valid = 1'b0;
        step; step;
        checks++;
        if (a_memEn !== 1'b1 || a_memAddr !== 32'd2 || a_memData !== 32'hD0) begin
            errors++;
            $display("FAIL emit_byte2: got en %b addr %0d data %h want 1 2 d0", a_memEn, a_memAddr, a_memData);
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        checks++;
        if ({a_memEn, a_proc_reset, a_busy, a_in_ready, a_done} !== 5'b01000 || a_memAddr !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: got %b addr %0d want 01000 addr 0",
                     {a_memEn, a_proc_reset, a_busy, a_in_ready, a_done}, a_memAddr);
        end
        begin_session;
        in_valid = 1'b1; in_data = prog[0]; in_last = 1'b1;
        step;
        in_valid = 1'b0; in_last = 1'b0;
        checks++;
        if (a_memEn !== 1'b1 || a_memAddr !== 32'd0 || a_memData !== 32'h13) begin
            errors++;
            $display("FAIL reload_addr0: got en %b addr %0d data %h want 1 0 13", a_memEn, a_memAddr, a_memData);
        end
    endtask

    initial begin
        test_reset;
        test_ignored_inputs;
        test_load_and_pass;
        test_fail_exit;
        test_timeout;
        test_exit_beats_timeout;
        test_reset_mid_emit;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
